// File: rtl/hot_page_pkg.sv
// Shared types for the hot-page migration dispatcher.
// Page-pair struct, channel FSM states and channel count.
package hot_page_pkg;

  localparam int NUM_MIG_CHAN = 2;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
  } page_pair_t;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_ISSUE,
    CH_WAIT
  } ch_state_e;

  function automatic logic is_zero_pair(page_pair_t p);
    return (p.src == '0) || (p.dst == '0);
  endfunction

endpackage

// File: rtl/hot_page_mig_dispatcher_grp_fifo.sv
// Group FIFO: DEPTH entries of packed page-pair groups.
// A pop in the same cycle frees the slot for a push while full.
module hot_page_grp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             push_ok_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign push_ok_o = do_push;
  assign data_o    = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/hot_page_mig_dispatcher.sv
// Buffers page-pair groups and issues them to two migration channels.
// HPPB_ZERO_SKIP_EN: skip pairs with a zero src or dst address.
module hot_page_mig_dispatcher
  import hot_page_pkg::*;
#(
  parameter int MIG_GRP_SIZE    = 16,
  parameter int GRP_DEPTH       = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               axi4_mm_clk,
  input  logic                               axi4_mm_rst,
  input  logic                               new_addr_available,
  input  logic [MIG_GRP_SIZE/2-1:0][63:0]    src_addr,
  input  logic [MIG_GRP_SIZE/2-1:0][63:0]    dst_addr,
  input  logic [MIG_GRP_SIZE/2-1:0][63:0]    src_addr1,
  input  logic [MIG_GRP_SIZE/2-1:0][63:0]    dst_addr1,
  output logic [NUM_MIG_CHAN-1:0]            mig_req_valid,
  input  logic [NUM_MIG_CHAN-1:0]            mig_req_ready,
  output logic [NUM_MIG_CHAN-1:0][63:0]      mig_req_src,
  output logic [NUM_MIG_CHAN-1:0][63:0]      mig_req_dst,
  input  logic [NUM_MIG_CHAN-1:0]            mig_done,
  output logic [63:0]                        mig_done_cnt,
  output logic                               grp_fifo_full,
  output logic [31:0]                        grp_drop_cnt,
  output logic                               busy
);

  localparam int NP = MIG_GRP_SIZE / 2;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef page_pair_t [NUM_MIG_CHAN-1:0][NP-1:0] grp_t;

  grp_t       wr_grp, hd_grp;
  logic       fifo_full, fifo_empty, push_ok, pop;
  logic       both_wait, drop;

  ch_state_e        st_q  [NUM_MIG_CHAN];
  ch_state_e        st_d  [NUM_MIG_CHAN];
  logic [IW-1:0]    idx_q [NUM_MIG_CHAN];
  logic [IW-1:0]    idx_d [NUM_MIG_CHAN];
  logic [OW-1:0]    out_q [NUM_MIG_CHAN];
  logic [OW-1:0]    out_d [NUM_MIG_CHAN];
  page_pair_t       cur   [NUM_MIG_CHAN];
  logic [NUM_MIG_CHAN-1:0] vld, hs, skip;

  logic [63:0] done_cnt_q, done_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    wr_grp = '0;
    for (int i = 0; i < NP; i++) begin
      wr_grp[0][i].src = src_addr[i];
      wr_grp[0][i].dst = dst_addr[i];
      wr_grp[1][i].src = src_addr1[i];
      wr_grp[1][i].dst = dst_addr1[i];
    end
  end

  hot_page_grp_fifo #(
    .WIDTH ($bits(grp_t)),
    .DEPTH (GRP_DEPTH)
  ) u_grp_fifo (
    .clk_i     (axi4_mm_clk),
    .rst_i     (axi4_mm_rst),
    .push_i    (new_addr_available),
    .pop_i     (pop),
    .data_i    (wr_grp),
    .data_o    (hd_grp),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .push_ok_o (push_ok)
  );

  assign both_wait = (st_q[0] == CH_WAIT) && (st_q[1] == CH_WAIT);
  assign pop       = both_wait;
  assign drop      = new_addr_available && !push_ok;

  // Data is zeroed while idle so outputs read 0 straight out of reset.
  always_comb begin
    for (int c = 0; c < NUM_MIG_CHAN; c++) begin
      cur[c] = hd_grp[c][idx_q[c]];
`ifdef HPPB_ZERO_SKIP_EN
      skip[c] = (st_q[c] == CH_ISSUE) && is_zero_pair(cur[c]);
`else
      skip[c] = 1'b0;
`endif
      vld[c] = (st_q[c] == CH_ISSUE) && !skip[c] &&
               (out_q[c] < OW'(MAX_OUTSTANDING));
      hs[c]  = vld[c] && mig_req_ready[c];
      mig_req_valid[c] = vld[c];
      mig_req_src[c]   = vld[c] ? cur[c].src : '0;
      mig_req_dst[c]   = vld[c] ? cur[c].dst : '0;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_MIG_CHAN; c++) begin
      st_d[c]  = st_q[c];
      idx_d[c] = idx_q[c];
      out_d[c] = out_q[c];
      unique case (st_q[c])
        CH_IDLE: begin
          if (!fifo_empty) begin
            st_d[c]  = CH_ISSUE;
            idx_d[c] = '0;
          end
        end
        CH_ISSUE: begin
          if (hs[c] || skip[c]) begin
            if (idx_q[c] == IW'(NP - 1)) st_d[c] = CH_WAIT;
            else idx_d[c] = idx_q[c] + 1'b1;
          end
        end
        CH_WAIT: begin
          if (both_wait) st_d[c] = CH_IDLE;
        end
        default: st_d[c] = CH_IDLE;
      endcase
      unique case (1'b1)
        hs[c] && !mig_done[c]:
          out_d[c] = out_q[c] + 1'b1;
        !hs[c] && mig_done[c] && (out_q[c] != '0):
          out_d[c] = out_q[c] - 1'b1;
        default:
          out_d[c] = out_q[c];
      endcase
    end
  end

  always_comb begin
    done_cnt_d = done_cnt_q + 64'(mig_done[0]) + 64'(mig_done[1]);
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      for (int c = 0; c < NUM_MIG_CHAN; c++) begin
        st_q[c]  <= CH_IDLE;
        idx_q[c] <= '0;
        out_q[c] <= '0;
      end
      done_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int c = 0; c < NUM_MIG_CHAN; c++) begin
        st_q[c]  <= st_d[c];
        idx_q[c] <= idx_d[c];
        out_q[c] <= out_d[c];
      end
      done_cnt_q <= done_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign mig_done_cnt  = done_cnt_q;
  assign grp_drop_cnt  = drop_cnt_q;
  assign grp_fifo_full = fifo_full;
  assign busy          = !fifo_empty || (out_q[0] != '0) || (out_q[1] != '0);

endmodule

// File: tb/tb_hot_page_mig_dispatcher.sv
// Directed bench for hot_page_mig_dispatcher.
// Expected pairs come from a per-channel queue filled at push time.
module tb_hot_page_mig_dispatcher;

  localparam int NP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nav = 1'b0;
  logic [NP-1:0][63:0] s0 = '0, d0 = '0, s1 = '0, d1 = '0;
  logic [1:0]       vld;
  logic [1:0]       rdy = '0;
  logic [1:0]       done = '0;
  logic [1:0][63:0] rsrc, rdst;
  logic [63:0]      dcnt;
  logic             full;
  logic [31:0]      dropc;
  logic             busy;

  hot_page_mig_dispatcher #(
    .MIG_GRP_SIZE    (2 * NP),
    .GRP_DEPTH       (2),
    .MAX_OUTSTANDING (4)
  ) dut (
    .axi4_mm_clk        (clk),
    .axi4_mm_rst        (rst),
    .new_addr_available (nav),
    .src_addr           (s0),
    .dst_addr           (d0),
    .src_addr1          (s1),
    .dst_addr1          (d1),
    .mig_req_valid      (vld),
    .mig_req_ready      (rdy),
    .mig_req_src        (rsrc),
    .mig_req_dst        (rdst),
    .mig_done           (done),
    .mig_done_cnt       (dcnt),
    .grp_fifo_full      (full),
    .grp_drop_cnt       (dropc),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] s;
    logic [63:0] d;
    int          seq;
    bit          last;
  } item_t;

  item_t       q [2][$];
  int          vectors = 0;
  int          errs = 0;
  int          pend [2];
  int          compl [2];
  int          hs_tot [2];
  int          gseq = 0;
  int          base0, base1;
  logic [63:0] exp_cnt = '0;

  function automatic logic [63:0] sa(int g, int c, int i);
    return 64'h0000_1000_0000_1000 | (64'(g) << 16) | (64'(c) << 8) | 64'(i);
  endfunction

  function automatic logic [63:0] da(int g, int c, int i);
    return sa(g, c, i) ^ 64'hFF00_0000_0000_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int g, input bit acc, input logic [NP-1:0] zm);
    item_t it;
    for (int i = 0; i < NP; i++) begin
      s0[i] = zm[i] ? 64'd0 : sa(g, 0, i);
      d0[i] = da(g, 0, i);
      s1[i] = zm[i] ? 64'd0 : sa(g, 1, i);
      d1[i] = da(g, 1, i);
    end
    nav = 1'b1;
    step();
    nav = 1'b0;
    if (acc) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < NP; i++) begin
`ifdef HPPB_ZERO_SKIP_EN
          if (zm[i]) continue;
`endif
          it.s    = (c == 1) ? s1[i] : s0[i];
          it.d    = (c == 1) ? d1[i] : d0[i];
          it.seq  = gseq;
          it.last = (i == NP - 1);
          q[c].push_back(it);
        end
      end
      gseq++;
    end
  endtask

  // Called when valid&ready is seen; the handshake lands on the next edge.
  task automatic obs_hs(input int c);
    item_t it;
    chk("hs_expected", 64'(q[c].size() != 0), 64'd1);
    if (q[c].size() != 0) begin
      it = q[c].pop_front();
      chk($sformatf("src_c%0d", c), rsrc[c], it.s);
      chk($sformatf("dst_c%0d", c), rdst[c], it.d);
      chk($sformatf("lockstep_c%0d", c), 64'(compl[1-c] >= it.seq), 64'd1);
      if (it.last) compl[c]++;
    end
    pend[c]++;
    hs_tot[c]++;
  endtask

  task automatic drain(input bit rnd, input int limit);
    int          cyc;
    bit          hold;
    logic [63:0] hsrc;
    logic [1:0]  r, dn;
    cyc  = 0;
    hold = 1'b0;
    hsrc = '0;
    while ((q[0].size() != 0 || q[1].size() != 0 ||
            pend[0] != 0 || pend[1] != 0) && cyc < limit) begin
      if (hold) begin
        chk("hold_valid", 64'(vld[0]), 64'd1);
        chk("hold_src", rsrc[0], hsrc);
      end
      r = rnd ? {1'b1, 1'($urandom_range(0, 1))} : 2'b11;
      rdy = r;
      for (int c = 0; c < 2; c++) dn[c] = (pend[c] > 0);
      for (int c = 0; c < 2; c++) if (vld[c] && r[c]) obs_hs(c);
      for (int c = 0; c < 2; c++) begin
        if (dn[c]) begin
          pend[c]--;
          exp_cnt++;
        end
      end
      done = dn;
      hold = vld[0] && !r[0];
      hsrc = rsrc[0];
      step();
      cyc++;
    end
    chk("drain_in_time", 64'(cyc < limit), 64'd1);
    rdy  = '0;
    done = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 2; c++) begin
      pend[c] = 0; compl[c] = 0; hs_tot[c] = 0;
    end
    repeat (3) step();
    chk("rst_valid", 64'(vld), 64'd0);
    chk("rst_src0", rsrc[0], 64'd0);
    chk("rst_cnt", dcnt, 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_drop", 64'(dropc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // One group, readies high, no completions: cap stalls at 4.
    push(1, 1'b1, '0);
    rdy = 2'b11;
    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < 2; c++) if (vld[c] && rdy[c]) obs_hs(c);
      step();
    end
    chk("t1_hs0_cap", 64'(hs_tot[0]), 64'd4);
    chk("t1_hs1_cap", 64'(hs_tot[1]), 64'd4);
    chk("t1_stall", 64'(vld), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    drain(1'b0, 200);
    repeat (3) step();
    chk("t1_cnt", dcnt, 64'd16);
    chk("t1_busy_end", 64'(busy), 64'd0);

    // Overflow: third group dropped, only first two ever issue.
    push(11, 1'b1, '0);
    push(12, 1'b1, '0);
    chk("t2_full", 64'(full), 64'd1);
    push(13, 1'b0, '0);
    chk("t2_drop", 64'(dropc), 64'd1);
    chk("t2_busy", 64'(busy), 64'd1);
    drain(1'b0, 400);
    repeat (3) step();
    chk("t2_full_end", 64'(full), 64'd0);
    chk("t2_busy_end", 64'(busy), 64'd0);
    chk("t2_cnt", dcnt, 64'd48);

    // Random ready on channel 0; channel 1 waits for it each group.
    push(31, 1'b1, '0);
    push(32, 1'b1, '0);
    drain(1'b1, 600);
    repeat (3) step();
    chk("t3_cnt", dcnt, 64'd80);
    chk("t3_busy_end", 64'(busy), 64'd0);

    // Spurious done, double done, handshake+done on one channel.
    rdy = 2'b00;
    push(21, 1'b1, '0);
    step();
    chk("t4_valid", 64'(vld), 64'd3);
    done = 2'b01;
    exp_cnt++;
    step();
    done = 2'b00;
    chk("t4_spur_cnt", dcnt, 64'd81);
    chk("t4_no_underflow", 64'(vld), 64'd3);
    rdy = 2'b11;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) if (vld[c]) obs_hs(c);
      step();
    end
    chk("t4_cap", 64'(vld), 64'd0);
    rdy = 2'b00;
    done = 2'b11;
    pend[0]--; pend[1]--;
    exp_cnt += 2;
    step();
    done = 2'b00;
    chk("t4_dbl_cnt", dcnt, 64'd83);
    chk("t4_dbl_valid", 64'(vld), 64'd3);
    rdy = 2'b01;
    done = 2'b01;
    obs_hs(0);
    pend[0]--;
    exp_cnt++;
    step();
    done = 2'b00;
    chk("t4_hsdone_cnt", dcnt, 64'd84);
    chk("t4_hsdone_valid", 64'(vld), 64'd3);
    chk("t4_idx5", rsrc[0], sa(21, 0, 5));
    obs_hs(0);
    step();
    chk("t4_cap_again", 64'(vld), 64'd2);
    rdy = 2'b00;
    drain(1'b0, 200);
    repeat (3) step();
    chk("t4_cnt", dcnt, exp_cnt);
    chk("t4_busy_end", 64'(busy), 64'd0);

    // Zero-address pairs 2 and 5.
    base0 = hs_tot[0];
    base1 = hs_tot[1];
    push(51, 1'b1, 8'b0010_0100);
    drain(1'b0, 200);
    repeat (3) step();
`ifdef HPPB_ZERO_SKIP_EN
    chk("t5_req0", 64'(hs_tot[0] - base0), 64'd6);
    chk("t5_req1", 64'(hs_tot[1] - base1), 64'd6);
`else
    chk("t5_req0", 64'(hs_tot[0] - base0), 64'd8);
    chk("t5_req1", 64'(hs_tot[1] - base1), 64'd8);
`endif
    chk("t5_cnt", dcnt, exp_cnt);

    // Asynchronous reset with 3 outstanding.
    push(61, 1'b1, '0);
    step();
    rdy = 2'b11;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 2; c++) if (vld[c]) obs_hs(c);
      step();
    end
    rdy = 2'b00;
    chk("t6_pre_valid", 64'(vld), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(vld), 64'd0);
    chk("t6_src0", rsrc[0], 64'd0);
    chk("t6_dst1", rdst[1], 64'd0);
    chk("t6_cnt", dcnt, 64'd0);
    chk("t6_drop", 64'(dropc), 64'd0);
    chk("t6_full", 64'(full), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    for (int c = 0; c < 2; c++) begin
      q[c].delete();
      pend[c] = 0;
      compl[c] = 0;
    end
    gseq = 0;
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    step();
    push(62, 1'b1, '0);
    step();
    chk("t6_restart_idx0", rsrc[0], sa(62, 0, 0));
    drain(1'b0, 200);
    repeat (3) step();
    chk("t6_cnt_end", dcnt, 64'd16);
    chk("t6_busy_end", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
